ldst_control_sequencer: RTL
===========================

Name: ldst_control_sequencer

Overview:
- Hardwired Moore control unit that generates the datapath control strobes for instruction fetch and the load/store class: ld, ldi, st.
- Replaces hand-timed control sequencing with a clocked state machine.
- Generalised over opcode encodings and over a configurable number of memory wait cycles.
- Sits between IR/CON outputs of the datapath and its register/bus enables; a run/stop handshake allows halting between instructions.

Parameters:
- OPCODE_W, 5, width of IR opcode field (IR[31:32-OPCODE_W]).
- MEM_WAIT, 0, extra cycles Read/Write held asserted before data is valid (0..15).
- OP_LD, 5'b00000, opcode value for ld.
- OP_LDI, 5'b00001, opcode value for ldi.
- OP_ST, 5'b00010, opcode value for st.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- IRregister  in  32  current instruction register contents.
- Stop  in  1  request halt at next instruction boundary.
- PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin  out  1 each  fetch/memory strobes.
- Gra, Grb, Rin, Rout, BAout, Yin, Cout, ZLOout, Write  out  1 each  operand/address strobes.
- AluAdd  out  1  selects ALU add operation for Z.
- Run  out  1  high while sequencing, low in HALT.
- IllegalOp  out  1  one-cycle pulse on unsupported opcode.
- StateOut  out  4  current state encoding (debug/bench visibility).

Behaviour:
- Reset (Reset=0, async): state=T0, all strobes 0, IllegalOp=0, Run=1, wait counter=0. Strobes are pure functions of state (+ wait counter), registered one cycle per state.
- T0: PCout, MARin, IncPC, Zin. If Stop=1 on entry edge, go HALT instead (no strobes).
- T1: Read, MDRin held for MEM_WAIT+1 cycles; ZLOout and PCin asserted only in the first of these cycles; MDRin latches on every cycle, so the final cycle's data wins. Counter counts 0..MEM_WAIT, then T2.
- T2: MDRout, IRin -> T3.
- T3: decode opcode = IRregister[31:32-OPCODE_W]. Match ld/ldi/st -> Grb, BAout, Yin; go T4. No match -> IllegalOp=1 for this cycle, no other strobes; go T0.
- T4: Cout, AluAdd, Zin -> T5. The C-sign-extended immediate plus Y (R0 reads as 0 via BAout) forms the effective address.
- T5, ldi: ZLOout, Gra, Rin -> T0.
- T5, ld/st: ZLOout, MARin -> T6.
- T6, ld: Read, MDRin held MEM_WAIT+1 cycles (same counter rule) -> T7.
- T6, st: Gra, Rout, MDRin, single cycle (Read=0 selects bus into MDR) -> T7.
- T7, ld: MDRout, Gra, Rin -> T0.
- T7, st: Write held MEM_WAIT+1 cycles -> T0.
- Opcode is captured into a register in T3 and used for T4-T7. An IR change after T3 has no effect.
- HALT: all strobes 0, Run=0. Leave to T0 when Stop=0; the first strobes appear in the cycle after the exit edge.
- Reset mid-instruction: immediate return to T0 and counter clear. No partial Write may persist past reset assertion.
- Mutual exclusion, as invariants: never Read&Write; at most one bus driver (PCout, MDRout, Rout, BAout, Cout, ZLOout) per cycle.
- Instruction latency, cycles:
  - ldi: 6+MEM_WAIT.
  - ld: 8+2*MEM_WAIT.
  - st: 8+2*MEM_WAIT.
  - illegal: 4+MEM_WAIT.

Decomposition:
- Shared package cpu_ctrl_pkg: state enum (T0..T7, HALT), default opcode constants OP_LD/OP_LDI/OP_ST, OPCODE_W default.
- One natural sub-module: mem_wait_counter (load/count/done, width 4). It is reused by T1, T6(ld) and T7(st).

Test Plan:
- ldi with IR=0x08800075 (R1, imm 0x75), MEM_WAIT=0 -> strobe trace T0..T5 exactly as above, in 6 cycles; Gra&Rin in cycle 6; no Write ever.
- ld with IR=0x00800075, MEM_WAIT=2 -> Read high for 3 cycles in T1 and 3 in T6; MDRin high in each; PCin only in T1's first cycle; Gra&Rin at cycle 12 (8+2*2).
- st with IR=0x11000045, MEM_WAIT=0 -> T6 has Gra,Rout,MDRin; T7 Write=1 for exactly 1 cycle; Read never overlaps Write.
- IR=0xF8000000 (opcode 0x1F) -> IllegalOp=1 for one cycle in T3; return to T0 next; no Rin/Write asserted.
- Stop=1 while in T4 of ld -> ld completes through T7; then HALT with Run=0 and all strobes 0; Stop=0 -> T0 with PCout=1 next cycle.
- Reset=0 asserted during st T7 with MEM_WAIT=3 -> Write drops within the same timestep (async); StateOut=T0; after release, fetch restarts with PCout=1.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the load/store control sequencer.
// Contents: sequencer state encoding, decoded instruction class, the
// registered strobe bundle, default opcode constants and a helper that
// maps a state to the strobes it drives.
package cpu_ctrl_pkg;

  localparam int         DEF_OPCODE_W = 5;
  localparam logic [4:0] DEF_OP_LD    = 5'b00000;
  localparam logic [4:0] DEF_OP_LDI   = 5'b00001;
  localparam logic [4:0] DEF_OP_ST    = 5'b00010;
  localparam int         WAIT_W       = 4;

  typedef enum logic [3:0] {
    T0   = 4'd0,
    T1   = 4'd1,
    T2   = 4'd2,
    T3   = 4'd3,
    T4   = 4'd4,
    T5   = 4'd5,
    T6   = 4'd6,
    T7   = 4'd7,
    HALT = 4'd8
  } state_e;

  typedef enum logic [1:0] {
    OPC_LD  = 2'd0,
    OPC_LDI = 2'd1,
    OPC_ST  = 2'd2,
    OPC_BAD = 2'd3
  } op_class_e;

  // Strobes that depend only on state (plus first-cycle and captured class).
  // The T3 decode strobes are not in here; they follow the live IR.
  typedef struct packed {
    logic pc_out;
    logic mar_in;
    logic inc_pc;
    logic z_in;
    logic pc_in;
    logic read;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic gra;
    logic rin;
    logic rout;
    logic zlo_out;
    logic cout;
    logic alu_add;
    logic write;
  } strobe_t;

  // first: set only in the first cycle of a multi-cycle memory state.
  function automatic strobe_t state_strobes(input state_e s, input logic first,
                                            input op_class_e op);
    strobe_t r;
    r = '0;
    case (s)
      T0: begin
        r.pc_out = 1'b1;
        r.mar_in = 1'b1;
        r.inc_pc = 1'b1;
        r.z_in   = 1'b1;
      end
      T1: begin
        r.read    = 1'b1;
        r.mdr_in  = 1'b1;
        r.zlo_out = first;
        r.pc_in   = first;
      end
      T2: begin
        r.mdr_out = 1'b1;
        r.ir_in   = 1'b1;
      end
      T4: begin
        r.cout    = 1'b1;
        r.alu_add = 1'b1;
        r.z_in    = 1'b1;
      end
      T5: begin
        r.zlo_out = 1'b1;
        if (op == OPC_LDI) begin
          r.gra = 1'b1;
          r.rin = 1'b1;
        end else begin
          r.mar_in = 1'b1;
        end
      end
      T6: begin
        if (op == OPC_ST) begin
          r.gra    = 1'b1;
          r.rout   = 1'b1;
          r.mdr_in = 1'b1;
        end else begin
          r.read   = 1'b1;
          r.mdr_in = 1'b1;
        end
      end
      T7: begin
        if (op == OPC_ST) begin
          r.write = 1'b1;
        end else begin
          r.mdr_out = 1'b1;
          r.gra     = 1'b1;
          r.rin     = 1'b1;
        end
      end
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Memory wait counter: counts 0..LIMIT while a memory phase is active.
// Ports: Clock, Reset (async active-low), load (clear to 0), count
// (advance by one), done (count has reached LIMIT).
module mem_wait_counter
  import cpu_ctrl_pkg::*;
#(
  parameter int              W     = WAIT_W,
  parameter logic [W-1:0]    LIMIT = '0
) (
  input  logic Clock,
  input  logic Reset,
  input  logic load,
  input  logic count,
  output logic done
);

  logic [W-1:0] cnt;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (count) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = (cnt == LIMIT);

endmodule

// File: rtl/ldst_control_sequencer.sv
// Moore control unit for instruction fetch and ld / ldi / st.
// Ports: Clock, Reset (async active-low), IRregister (instruction word),
// Stop (halt at next instruction boundary); datapath strobes out,
// Run (low in HALT), IllegalOp (pulse in T3 on unknown opcode),
// StateOut (current state encoding).
//
// state | meaning
// T0    | PC to MAR, increment PC into Z
// T1    | memory read of instruction (MEM_WAIT+1 cycles), Z to PC first cycle
// T2    | MDR to IR
// T3    | decode; base register (or 0) into Y, or flag illegal opcode
// T4    | Y + sign-extended C into Z (effective address / immediate)
// T5    | ldi: Z to Ra; ld/st: Z to MAR
// T6    | ld: memory read (MEM_WAIT+1 cycles); st: Ra into MDR
// T7    | ld: MDR to Ra; st: memory write (MEM_WAIT+1 cycles)
// HALT  | stopped between instructions, no strobes, Run low
module ldst_control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int                  OPCODE_W = DEF_OPCODE_W,
  parameter int                  MEM_WAIT = 0,
  parameter logic [OPCODE_W-1:0] OP_LD    = OPCODE_W'(DEF_OP_LD),
  parameter logic [OPCODE_W-1:0] OP_LDI   = OPCODE_W'(DEF_OP_LDI),
  parameter logic [OPCODE_W-1:0] OP_ST    = OPCODE_W'(DEF_OP_ST)
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] IRregister,
  input  logic        Stop,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        Zin,
  output logic        PCin,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Gra,
  output logic        Grb,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Yin,
  output logic        Cout,
  output logic        ZLOout,
  output logic        Write,
  output logic        AluAdd,
  output logic        Run,
  output logic        IllegalOp,
  output logic [3:0]  StateOut
);

  state_e    state;
  strobe_t   strb;
  op_class_e op_q;
  op_class_e live_cls;
  logic      run_q;
  logic      started;
  logic      wait_phase;
  logic      wait_done;
  state_e    t0_target;

  logic [OPCODE_W-1:0] opcode;
  logic                unused_ir_bits;

  assign opcode         = IRregister[31 -: OPCODE_W];
  assign unused_ir_bits = ^IRregister[31-OPCODE_W:0];

  always_comb begin
    live_cls = OPC_BAD;
    if (opcode == OP_LD)       live_cls = OPC_LD;
    else if (opcode == OP_LDI) live_cls = OPC_LDI;
    else if (opcode == OP_ST)  live_cls = OPC_ST;
  end

  // Every instruction boundary re-checks Stop.
  assign t0_target = Stop ? HALT : T0;

  assign wait_phase = (state == T1)
                    | ((state == T6) & (op_q == OPC_LD))
                    | ((state == T7) & (op_q == OPC_ST));

  mem_wait_counter #(
    .W    (WAIT_W),
    .LIMIT(WAIT_W'(MEM_WAIT))
  ) u_wait (
    .Clock(Clock),
    .Reset(Reset),
    .load (~wait_phase),
    .count(wait_phase & ~wait_done),
    .done (wait_done)
  );

  // Strobes for the next state are registered on the transition edge, so
  // they line up with StateOut. The first edge after reset performs the
  // initial T0 entry (reset itself leaves all strobes low).
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state   <= T0;
      strb    <= '0;
      op_q    <= OPC_BAD;
      run_q   <= 1'b1;
      started <= 1'b0;
    end else if (!started) begin
      started <= 1'b1;
      state   <= t0_target;
      strb    <= state_strobes(t0_target, 1'b1, op_q);
      run_q   <= ~Stop;
    end else begin
      case (state)
        T0: begin
          state <= T1;
          strb  <= state_strobes(T1, 1'b1, op_q);
        end
        T1: begin
          if (wait_done) begin
            state <= T2;
            strb  <= state_strobes(T2, 1'b1, op_q);
          end else begin
            strb  <= state_strobes(T1, 1'b0, op_q);
          end
        end
        T2: begin
          state <= T3;
          strb  <= state_strobes(T3, 1'b1, op_q);
        end
        T3: begin
          if (live_cls != OPC_BAD) begin
            op_q  <= live_cls;
            state <= T4;
            strb  <= state_strobes(T4, 1'b1, live_cls);
          end else begin
            state <= t0_target;
            strb  <= state_strobes(t0_target, 1'b1, op_q);
            run_q <= ~Stop;
          end
        end
        T4: begin
          state <= T5;
          strb  <= state_strobes(T5, 1'b1, op_q);
        end
        T5: begin
          if (op_q == OPC_LDI) begin
            state <= t0_target;
            strb  <= state_strobes(t0_target, 1'b1, op_q);
            run_q <= ~Stop;
          end else begin
            state <= T6;
            strb  <= state_strobes(T6, 1'b1, op_q);
          end
        end
        T6: begin
          if (op_q == OPC_LD && !wait_done) begin
            strb  <= state_strobes(T6, 1'b0, op_q);
          end else begin
            state <= T7;
            strb  <= state_strobes(T7, 1'b1, op_q);
          end
        end
        T7: begin
          if (op_q == OPC_ST && !wait_done) begin
            strb  <= state_strobes(T7, 1'b0, op_q);
          end else begin
            state <= t0_target;
            strb  <= state_strobes(t0_target, 1'b1, op_q);
            run_q <= ~Stop;
          end
        end
        HALT: begin
          if (!Stop) begin
            state <= T0;
            strb  <= state_strobes(T0, 1'b1, op_q);
            run_q <= 1'b1;
          end
        end
        default: begin
          state <= T0;
          strb  <= '0;
          run_q <= 1'b1;
        end
      endcase
    end
  end

  // IR is only loaded at the end of T2, so the decode strobes in T3 follow
  // the live IR rather than a value registered before it was valid.
  logic in_t3;
  logic legal;
  assign in_t3 = (state == T3);
  assign legal = (live_cls != OPC_BAD);

  assign PCout     = strb.pc_out;
  assign MARin     = strb.mar_in;
  assign IncPC     = strb.inc_pc;
  assign Zin       = strb.z_in;
  assign PCin      = strb.pc_in;
  assign Read      = strb.read;
  assign MDRin     = strb.mdr_in;
  assign MDRout    = strb.mdr_out;
  assign IRin      = strb.ir_in;
  assign Gra       = strb.gra;
  assign Rin       = strb.rin;
  assign Rout      = strb.rout;
  assign ZLOout    = strb.zlo_out;
  assign Cout      = strb.cout;
  assign AluAdd    = strb.alu_add;
  assign Write     = strb.write;
  assign Grb       = in_t3 & legal;
  assign BAout     = in_t3 & legal;
  assign Yin       = in_t3 & legal;
  assign IllegalOp = in_t3 & ~legal;
  assign Run       = run_q;
  assign StateOut  = state;

endmodule
